if_fetch_unit: RTL and testbench

- Instruction-fetch front end that produces the PC/IR pair and valid flag consumed by the IF/ID pipeline latch.
- Sequences the PC, issues single-outstanding requests to instruction memory over a ready/valid handshake, and buffers returned words in a small FIFO.
- Honours the stall, enable and redirect (branch/jump flush) controls shared with the IF/ID latch.
- Sits between instruction memory and the IF/ID latch.

---
 rtl/if_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: sequences the PC, issues single-outstanding
// imem requests and queues returned words for the IF/ID latch.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EN,
    input  logic        Data_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_ir
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       issued_pc_q, issued_pc_d;
    logic              outstanding_q, outstanding_d;
    logic              imem_req_q, imem_req_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       buf_pc_q [BUF_DEPTH];
    logic [31:0]       buf_pc_d [BUF_DEPTH];
    logic [31:0]       buf_ir_q [BUF_DEPTH];
    logic [31:0]       buf_ir_d [BUF_DEPTH];

    logic accept;
    logic push;
    logic pop;

    // imem_req_q is only ever set while in S_REQ, so this is a true handshake.
    assign accept = imem_req_q && imem_ready;
    assign push   = (state_q == S_WAIT) && imem_rvalid && !redirect;
    assign pop    = EN && !Data_stall && (count_q != '0) && !redirect;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        issued_pc_d   = issued_pc_q;
        outstanding_d = outstanding_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        buf_pc_d      = buf_pc_q;
        buf_ir_d      = buf_ir_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // A response still in flight must be swallowed before refetching.
            if (accept) begin
                issued_pc_d   = fetch_pc_q;
                outstanding_d = 1'b1;
                state_d       = S_DROP;
            end else if (outstanding_q && !imem_rvalid) begin
                state_d = S_DROP;
            end else begin
                outstanding_d = 1'b0;
                state_d       = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (accept) begin
                        issued_pc_d   = fetch_pc_q;
                        fetch_pc_d    = fetch_pc_q + 32'd4;
                        outstanding_d = 1'b1;
                        state_d       = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        outstanding_d = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        outstanding_d = 1'b0;
                        state_d       = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase

            if (push) begin
                buf_pc_d[wr_ptr_q] = issued_pc_q;
                buf_ir_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d           = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Reserving a slot for the in-flight word is what makes overflow impossible.
        imem_req_d = (state_d == S_REQ) && ((count_d + CNT_W'(outstanding_d)) < FULL_CNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC;
            issued_pc_q   <= RESET_PC;
            outstanding_q <= 1'b0;
            imem_req_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc_q[i] <= '0;
                buf_ir_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            issued_pc_q   <= issued_pc_d;
            outstanding_q <= outstanding_d;
            imem_req_q    <= imem_req_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            buf_pc_q      <= buf_pc_d;
            buf_ir_q      <= buf_ir_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = fetch_pc_q;
    assign if_valid  = (count_q != '0);
    assign if_pc     = if_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
    assign if_ir     = if_valid ? buf_ir_q[rd_ptr_q] : NOP_INSTR;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count_q == FULL_CNT)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small variable-latency instruction memory.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        dataStall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        ifValid;
    logic [31:0] ifPc;
    logic [31:0] ifIr;

    int          compareCount;
    int          mismatchCount;
    int          memLatency;
    int          waitCnt;
    logic [31:0] pendAddr;
    logic        watch10;
    logic        saw10;

    if_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .EN         (en),
        .Data_stall (dataStall),
        .redirect   (redirect),
        .redirect_pc(redirectPc),
        .imem_req   (imemReq),
        .imem_addr  (imemAddr),
        .imem_ready (imemReady),
        .imem_rvalid(imemRvalid),
        .imem_rdata (imemRdata),
        .if_valid   (ifValid),
        .if_pc      (ifPc),
        .if_ir      (ifIr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
    endfunction

    // Memory answers each accepted request memLatency cycles later; reset drops anything pending.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            imemRvalid <= 1'b0;
            imemRdata  <= 32'h0;
            waitCnt    <= 0;
            pendAddr   <= 32'h0;
        end else begin
            imemRvalid <= 1'b0;
            if (waitCnt == 1) begin
                imemRvalid <= 1'b1;
                imemRdata  <= memWord(pendAddr);
                waitCnt    <= 0;
            end else if (waitCnt > 1) begin
                waitCnt <= waitCnt - 1;
            end
            if (imemReq && imemReady) begin
                pendAddr <= imemAddr;
                if (memLatency <= 1) begin
                    imemRvalid <= 1'b1;
                    imemRdata  <= memWord(imemAddr);
                end else begin
                    waitCnt <= memLatency - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (watch10 && ifValid && (ifPc == 32'h10)) saw10 = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic s, input logic r, input logic [31:0] rpc);
        en         = e;
        dataStall  = s;
        redirect   = r;
        redirectPc = rpc;
    endtask

    task automatic applyReset(input int latency);
        rst        = 1'b0;
        imemReady  = 1'b1;
        memLatency = latency;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 60 && !ifValid; i++) @(negedge clk);
        checkOutput(tag, {31'd0, ifValid}, 32'd1);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        watch10       = 1'b0;
        saw10         = 1'b0;
        rst           = 1'b0;
        imemReady     = 1'b1;
        memLatency    = 1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset values
        @(negedge clk);
        checkOutput("rst_req",   {31'd0, imemReq}, 32'd0);
        checkOutput("rst_addr",  imemAddr,         32'h0);
        checkOutput("rst_valid", {31'd0, ifValid}, 32'd0);
        checkOutput("rst_pc",    ifPc,             32'h0);
        checkOutput("rst_ir",    ifIr,             32'h0000_0013);

        // First fetch and a Data_stall that fills the buffer
        applyReset(1);
        @(negedge clk);
        checkOutput("t1_req",   {31'd0, imemReq}, 32'd1);
        checkOutput("t1_addr",  imemAddr,         32'h0);
        @(negedge clk);
        checkOutput("t1_wait",  {31'd0, imemReq}, 32'd0);
        checkOutput("t1_nov",   {31'd0, ifValid}, 32'd0);
        @(negedge clk);
        checkOutput("t1_valid", {31'd0, ifValid}, 32'd1);
        checkOutput("t1_pc",    ifPc,             32'h0);
        checkOutput("t1_ir",    ifIr,             32'h0050_0093);
        @(negedge clk);
        checkOutput("t2_popped", {31'd0, ifValid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) @(negedge clk);
        checkOutput("t2_full_req", {31'd0, imemReq}, 32'd0);
        checkOutput("t2_hold_v",   {31'd0, ifValid}, 32'd1);
        checkOutput("t2_hold_pc",  ifPc,             32'h4);
        checkOutput("t2_hold_ir",  ifIr,             32'hC0DE_0004);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("t2_next_v",  {31'd0, ifValid}, 32'd1);
        checkOutput("t2_next_pc", ifPc,             32'h8);
        checkOutput("t2_next_ir", ifIr,             32'hC0DE_0008);

        // Redirect while the request to 0x10 is still outstanding
        applyReset(3);
        for (int i = 0; i < 100 && !(imemReq && imemAddr == 32'h10); i++) @(negedge clk);
        checkOutput("t3_reach10", {31'd0, (imemReq && imemAddr == 32'h10)}, 32'd1);
        @(negedge clk);
        checkOutput("t3_inflight", {31'd0, imemReq}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0102);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        watch10 = 1'b1;
        checkOutput("t3_addr",     imemAddr,         32'h100);
        checkOutput("t3_drop_req", {31'd0, imemReq}, 32'd0);
        checkOutput("t3_flush_v",  {31'd0, ifValid}, 32'd0);
        checkOutput("t3_flush_ir", ifIr,             32'h0000_0013);
        @(negedge clk);
        checkOutput("t3_drop_req2", {31'd0, imemReq}, 32'd0);
        @(negedge clk);
        checkOutput("t3_req_after", {31'd0, imemReq}, 32'd1);
        checkOutput("t3_addr_after", imemAddr,        32'h100);
        waitValid("t3_target_v");
        checkOutput("t3_target_pc", ifPc, 32'h100);
        checkOutput("t3_target_ir", ifIr, 32'hC0DE_0100);
        repeat (10) @(negedge clk);
        watch10 = 1'b0;
        checkOutput("t3_no_pc10", {31'd0, saw10}, 32'd0);

        // Redirect coincident with a response and a pop
        applyReset(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 60 && !(ifValid && imemRvalid); i++) @(negedge clk);
        checkOutput("t4_setup",   {31'd0, (ifValid && imemRvalid)}, 32'd1);
        checkOutput("t4_head_pc", ifPc, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_v",    {31'd0, ifValid}, 32'd0);
        checkOutput("t4_ir",   ifIr,             32'h0000_0013);
        checkOutput("t4_req",  {31'd0, imemReq}, 32'd1);
        checkOutput("t4_addr", imemAddr,         32'h200);
        waitValid("t4_target_v");
        checkOutput("t4_target_pc", ifPc, 32'h200);

        // Address wrap at 0xFFFFFFFC, redirect applied with EN=0
        applyReset(1);
        imemReady = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_addr", imemAddr,         32'hFFFF_FFFC);
        checkOutput("t5_req",  {31'd0, imemReq}, 32'd1);
        imemReady = 1'b1;
        @(negedge clk);
        checkOutput("t5_wrap",     imemAddr,         32'h0);
        checkOutput("t5_wait_req", {31'd0, imemReq}, 32'd0);
        waitValid("t5_v");
        checkOutput("t5_pc", ifPc, 32'hFFFF_FFFC);
        checkOutput("t5_ir", ifIr, 32'h3F21_FFFC);
        repeat (3) @(negedge clk);
        checkOutput("t5_en_hold", ifPc, 32'hFFFF_FFFC);

        // Asynchronous reset in the middle of a fetch
        applyReset(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 60 && !(ifValid && imemReq); i++) @(negedge clk);
        checkOutput("t6_setup", {31'd0, (ifValid && imemReq)}, 32'd1);
        @(negedge clk);
        checkOutput("t6_pre_req", {31'd0, imemReq}, 32'd0);
        checkOutput("t6_pre_v",   {31'd0, ifValid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_req",  {31'd0, imemReq}, 32'd0);
        checkOutput("t6_rst_addr", imemAddr,         32'h0);
        checkOutput("t6_rst_v",    {31'd0, ifValid}, 32'd0);
        checkOutput("t6_rst_pc",   ifPc,             32'h0);
        checkOutput("t6_rst_ir",   ifIr,             32'h0000_0013);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_restart_req",  {31'd0, imemReq}, 32'd1);
        checkOutput("t6_restart_addr", imemAddr,         32'h0);
        waitValid("t6_restart_v");
        checkOutput("t6_restart_pc", ifPc, 32'h0);
        checkOutput("t6_restart_ir", ifIr, 32'h0050_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
